// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR sequencer: address map, op codes,
// FSM states and mstatus field layout.
package csr_pkg;

  localparam int OP_W   = 3;
  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] ADDR_MSTATUS = 12'h300;
  localparam logic [ADDR_W-1:0] ADDR_MTVEC   = 12'h305;
  localparam logic [ADDR_W-1:0] ADDR_MEPC    = 12'h341;
  localparam logic [ADDR_W-1:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [OP_W-1:0] OP_CSRRW = 3'd0;
  localparam logic [OP_W-1:0] OP_CSRRS = 3'd1;
  localparam logic [OP_W-1:0] OP_CSRRC = 3'd2;
  localparam logic [OP_W-1:0] OP_ECALL = 3'd3;
  localparam logic [OP_W-1:0] OP_MRET  = 3'd4;

  localparam logic [1:0] IDX_MSTATUS = 2'd0;
  localparam logic [1:0] IDX_MTVEC   = 2'd1;
  localparam logic [1:0] IDX_MEPC    = 2'd2;
  localparam logic [1:0] IDX_MCAUSE  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_SAVE_EPC,
    S_SAVE_CAUSE,
    S_SAVE_STATUS,
    S_RESTORE,
    S_RESP
  } state_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP     = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_RST_DEF = 32'h0000_1800;
  localparam logic [31:0] ECALL_CAUSE_DEF = 32'd11;

  // Returns {hit, index}; hit=0 for any unmapped address.
  function automatic logic [2:0] decode_addr(input logic [ADDR_W-1:0] addr);
    case (addr)
      ADDR_MSTATUS: return {1'b1, IDX_MSTATUS};
      ADDR_MTVEC:   return {1'b1, IDX_MTVEC};
      ADDR_MEPC:    return {1'b1, IDX_MEPC};
      ADDR_MCAUSE:  return {1'b1, IDX_MCAUSE};
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/csr_seq_ctrl_if.sv
// Request/response/redirect bundle between the core (master) and the CSR
// sequencer (slave).
interface csr_seq_ctrl_if
  import csr_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   req_pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_illegal;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_regfile.sv
// mstatus/mtvec/mepc/mcause storage behind a single write port; WARL masking
// is applied on the way in so the stored value is always the readable value.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(MSTATUS_RST_DEF)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [1:0]      idx,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus <= MSTATUS_RST;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (we) begin
      case (idx)
        IDX_MSTATUS: mstatus <= (wdata & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_MPP);
        IDX_MTVEC:   mtvec   <= {wdata[XLEN-1:2], 2'b00};
        IDX_MEPC:    mepc    <= {wdata[XLEN-1:2], 2'b00};
        default:     mcause  <= wdata;
      endcase
    end
  end

endmodule

// File: rtl/csr_seq_ctrl.sv
// Machine-mode CSR sequencer: serialises CSR ops, ecall trap entry and mret
// onto one register-file write port, one write per cycle.
//
//   state        | meaning
//   S_IDLE       | ready for a request
//   S_ACCESS     | CSRRW/S/C read-old + write
//   S_SAVE_EPC   | ecall: mepc <= pc
//   S_SAVE_CAUSE | ecall: mcause <= ECALL_CAUSE
//   S_SAVE_STATUS| ecall: MPIE <= MIE, MIE <= 0
//   S_RESTORE    | mret: MIE <= MPIE, MPIE <= 1
//   S_RESP       | response held until resp_ready
module csr_seq_ctrl
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(ECALL_CAUSE_DEF),
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(MSTATUS_RST_DEF)
) (
  input  logic            clock,
  input  logic            reset,
  csr_seq_ctrl_if.slave   bus,
  output logic [XLEN-1:0] csr_0,
  output logic [XLEN-1:0] csr_1,
  output logic [XLEN-1:0] csr_2,
  output logic [XLEN-1:0] csr_3
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [1:0]      idx_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rdata_q;
  logic            illegal_q;

  logic            accept;
  logic [2:0]      dec;
  logic            dec_illegal;
  logic [XLEN-1:0] old_val;
  logic            we;
  logic [1:0]      widx;
  logic [XLEN-1:0] wval;

  csr_regfile #(
    .XLEN        (XLEN),
    .MSTATUS_RST (MSTATUS_RST)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .idx     (widx),
    .wdata   (wval),
    .mstatus (csr_0),
    .mtvec   (csr_1),
    .mepc    (csr_2),
    .mcause  (csr_3)
  );

  assign accept      = (state_q == S_IDLE) && bus.req_valid;
  assign dec         = decode_addr(bus.req_addr);
  assign dec_illegal = (bus.req_op > OP_MRET) || ((bus.req_op <= OP_CSRRC) && !dec[2]);

  always_comb begin
    case (idx_q)
      IDX_MSTATUS: old_val = csr_0;
      IDX_MTVEC:   old_val = csr_1;
      IDX_MEPC:    old_val = csr_2;
      default:     old_val = csr_3;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= bus.req_op;
        idx_q     <= dec[1:0];
        wdata_q   <= bus.req_wdata;
        pc_q      <= bus.req_pc;
        rdata_q   <= '0;
        illegal_q <= dec_illegal;
      end else if (state_q == S_ACCESS) begin
        rdata_q <= old_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    widx    = idx_q;
    wval    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (dec_illegal)                state_d = S_RESP;
          else if (bus.req_op == OP_ECALL) state_d = S_SAVE_EPC;
          else if (bus.req_op == OP_MRET)  state_d = S_RESTORE;
          else                             state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Set/clear with a zero mask must not write (side-effect-free read).
        case (op_q)
          OP_CSRRW: we = 1'b1;
          OP_CSRRS: begin we = |wdata_q; wval = old_val | wdata_q;  end
          default:  begin we = |wdata_q; wval = old_val & ~wdata_q; end
        endcase
        state_d = S_RESP;
      end
      S_SAVE_EPC: begin
        we      = 1'b1;
        widx    = IDX_MEPC;
        wval    = {pc_q[XLEN-1:2], 2'b00};
        state_d = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        we      = 1'b1;
        widx    = IDX_MCAUSE;
        wval    = ECALL_CAUSE;
        state_d = S_SAVE_STATUS;
      end
      S_SAVE_STATUS: begin
        we                 = 1'b1;
        widx               = IDX_MSTATUS;
        wval               = csr_0;
        wval[MSTATUS_MPIE] = csr_0[MSTATUS_MIE];
        wval[MSTATUS_MIE]  = 1'b0;
        state_d            = S_RESP;
      end
      S_RESTORE: begin
        we                 = 1'b1;
        widx               = IDX_MSTATUS;
        wval               = csr_0;
        wval[MSTATUS_MIE]  = csr_0[MSTATUS_MPIE];
        wval[MSTATUS_MPIE] = 1'b1;
        state_d            = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Redirect target is read live in RESP so it reflects every completed write.
  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = (state_q == S_RESP);
  assign bus.resp_rdata     = bus.resp_valid ? rdata_q : '0;
  assign bus.resp_illegal   = bus.resp_valid && illegal_q;
  assign bus.redirect_valid = bus.resp_valid && !illegal_q && ((op_q == OP_ECALL) || (op_q == OP_MRET));
  assign bus.redirect_pc    = !bus.redirect_valid ? '0 : (op_q == OP_ECALL) ? csr_1 : csr_2;

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Directed plus randomized bench for csr_seq_ctrl against an array-based
// model of the four machine-mode CSRs.
module tb_csr_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] csr_0, csr_1, csr_2, csr_3;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m [4];

  csr_seq_ctrl_if #(.XLEN(32)) bus ();

  csr_seq_ctrl #(
    .XLEN        (32),
    .ECALL_CAUSE (32'd11),
    .MSTATUS_RST (32'h0000_1800)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .csr_0 (csr_0),
    .csr_1 (csr_1),
    .csr_2 (csr_2),
    .csr_3 (csr_3)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_csrs(input string tag);
    chk({tag, ":mstatus"}, csr_0, m[0]);
    chk({tag, ":mtvec"},   csr_1, m[1]);
    chk({tag, ":mepc"},    csr_2, m[2]);
    chk({tag, ":mcause"},  csr_3, m[3]);
  endtask

  function automatic void model_reset();
    m[0] = 32'h0000_1800;
    m[1] = 32'h0;
    m[2] = 32'h0;
    m[3] = 32'h0;
  endfunction

  function automatic int addr_index(input logic [11:0] a);
    if (a == 12'h300) return 0;
    if (a == 12'h305) return 1;
    if (a == 12'h341) return 2;
    if (a == 12'h342) return 3;
    return -1;
  endfunction

  // Value a CSR reads back after software writes v to it.
  function automatic logic [31:0] legalize(input int i, input logic [31:0] v);
    if (i == 0) return (v & 32'h88) | 32'h1800;
    if (i == 3) return v;
    return v & 32'hFFFF_FFFC;
  endfunction

  task automatic model_step(input int op, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [31:0] pc, output logic [31:0] rdata,
                            output logic ill, output logic redir, output logic [31:0] rpc,
                            output int lat);
    int i;
    logic mie, mpie;
    i     = addr_index(addr);
    rdata = 32'h0;
    ill   = 1'b0;
    redir = 1'b0;
    rpc   = 32'h0;
    lat   = 2;
    if (op > 4 || (op <= 2 && i < 0)) begin
      ill = 1'b1;
      lat = 1;
    end else if (op == 3) begin
      m[2]  = pc & 32'hFFFF_FFFC;
      m[3]  = 32'd11;
      mie   = m[0][3];
      m[0]  = 32'h1800 | (32'(mie) << 7);
      redir = 1'b1;
      rpc   = m[1];
      lat   = 4;
    end else if (op == 4) begin
      mpie  = m[0][7];
      m[0]  = 32'h1800 | 32'h80 | (32'(mpie) << 3);
      redir = 1'b1;
      rpc   = m[2];
    end else begin
      rdata = m[i];
      if (op == 0)             m[i] = legalize(i, wd);
      else if (wd != 0 && op == 1) m[i] = legalize(i, m[i] | wd);
      else if (wd != 0)        m[i] = legalize(i, m[i] & ~wd);
    end
  endtask

  task automatic do_req(input string tag, input int op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc, input int hold);
    logic [31:0] e_rdata, e_rpc;
    logic        e_ill, e_redir;
    int          e_lat, lat;
    model_step(op, addr, wd, pc, e_rdata, e_ill, e_redir, e_rpc, e_lat);
    chk({tag, ":req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'(op);
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_pc    = pc;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    chk({tag, ":latency"},        32'(lat), 32'(e_lat));
    chk({tag, ":resp_rdata"},     bus.resp_rdata, e_rdata);
    chk({tag, ":resp_illegal"},   32'(bus.resp_illegal), 32'(e_ill));
    chk({tag, ":redirect_valid"}, 32'(bus.redirect_valid), 32'(e_redir));
    chk({tag, ":redirect_pc"},    bus.redirect_pc, e_rpc);
    check_csrs(tag);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, bus.resp_rdata, e_rdata);
      chk({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, ":resp_done"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_csrs(tag);
    chk({tag, ":req_ready"},      32'(bus.req_ready), 32'd1);
    chk({tag, ":resp_valid"},     32'(bus.resp_valid), 32'd0);
    chk({tag, ":resp_illegal"},   32'(bus.resp_illegal), 32'd0);
    chk({tag, ":redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    chk({tag, ":resp_rdata"},     bus.resp_rdata, 32'd0);
    chk({tag, ":redirect_pc"},    bus.redirect_pc, 32'd0);
  endtask

  initial begin
    logic [11:0] addrs [4];
    int          r, op;
    logic [11:0] a;
    logic [31:0] wd;
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;

    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_pc     = '0;
    bus.resp_ready = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("reset");
    chk("reset:mstatus_const", csr_0, 32'h0000_1800);

    do_req("rw_mtvec", 0, 12'h305, 32'h8000_0103, 32'h0, 0);
    chk("rw_mtvec:const", csr_1, 32'h8000_0100);
    do_req("rs_mtvec_zero", 1, 12'h305, 32'h0, 32'h0, 0);
    do_req("rw_mstatus", 0, 12'h300, 32'h8, 32'h0, 0);
    do_req("ecall", 3, 12'h000, 32'h0, 32'h8000_0046, 0);
    chk("ecall:mepc_const", csr_2, 32'h8000_0044);
    chk("ecall:mstatus_const", csr_0, 32'h0000_1880);
    do_req("mret", 4, 12'h000, 32'h0, 32'h0, 0);
    chk("mret:mstatus_const", csr_0, 32'h0000_1888);
    do_req("ill_addr", 0, 12'h7C0, 32'hFFFF_FFFF, 32'h0, 0);
    do_req("ill_op", 6, 12'h300, 32'hFFFF_FFFF, 32'h0, 0);
    do_req("rc_hold", 2, 12'h300, 32'h8, 32'h0, 5);
    do_req("rw_mcause", 0, 12'h342, 32'hDEAD_BEEF, 32'h0, 0);
    do_req("rs_mstatus_all", 1, 12'h300, 32'hFFFF_FFFF, 32'h0, 2);

    // Reset landing in the middle of an ecall sequence.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_addr  = 12'h0;
    bus.req_wdata = 32'h0;
    bus.req_pc    = 32'h1234_5677;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("mid_ecall:mepc", csr_2, 32'h1234_5674);
    chk("mid_ecall:req_ready", 32'(bus.req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("after_reset");

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       op = r % 3;
      else if (r == 6) op = 3;
      else if (r == 7) op = 4;
      else             op = int'($urandom_range(5, 7));
      a  = ($urandom_range(0, 4) == 0) ? 12'($urandom()) : addrs[$urandom_range(0, 3)];
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      do_req("rand", op, a, wd, $urandom(), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_seq_ctrl.md
Name: csr_seq_ctrl

Overview:
- Owns the machine-mode CSRs (mstatus, mtvec, mepc, mcause) of the single-cycle NPC.
- Sequences every update to them through one write port: CSR instructions, ecall trap entry and mret.
- The core hands over one request at a time via valid/ready and gets back the read data and/or a PC redirect.
- csr_0..csr_3 drive the simulation CSR display hook in index order mstatus, mtvec, mepc, mcause.

Parameters:
- XLEN, 32, data/PC width
- ECALL_CAUSE, 11, value written to mcause on ecall (M-mode environment call)
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=3)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept a request
- req_op  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal
- req_addr  in  12  CSR address (ignored for ECALL/MRET)
- req_wdata  in  XLEN  rs1/zimm operand
- req_pc  in  XLEN  PC of the requesting instruction
- resp_valid  out  1  response available
- resp_ready  in  1  core consumes the response
- resp_rdata  out  XLEN  old CSR value (CSR ops); 0 otherwise
- resp_illegal  out  1  illegal op or unknown address
- redirect_valid  out  1  qualifies redirect_pc; only asserted with resp_valid
- redirect_pc  out  XLEN  next PC for ECALL/MRET
- csr_0..csr_3  out  XLEN each  current mstatus, mtvec, mepc, mcause

Behaviour:
- Reset values:
  - State is IDLE.
  - mstatus=MSTATUS_RST; mtvec, mepc and mcause are 0.
  - req_ready=1; resp_valid, resp_illegal and redirect_valid are 0; resp_rdata and redirect_pc are 0.
- Reset asserted in any state aborts the operation, returns to IDLE and restores all reset values.
- Address map:
  - 0x300 mstatus; 0x305 mtvec; 0x341 mepc; 0x342 mcause.
  - Any other address is illegal.
- WARL rules:
  - mstatus: only MIE[3], MPIE[7] are writable; MPP[12:11] always reads 3; all other bits read 0.
  - mtvec[1:0] and mepc[1:0] always read 0.
  - mcause is fully writable.
- Handshake:
  - A request is accepted on clock edge with req_valid && req_ready.
  - req_ready=1 only in IDLE, and the controller captures all request fields on acceptance.
  - resp_valid holds in RESP until resp_ready=1; then the controller returns to IDLE.
  - A new request can be accepted the cycle after that.
- FSM: IDLE, ACCESS, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE, RESP.
- Transitions out of IDLE on acceptance:
  - op 0-2 with a valid address goes to ACCESS.
  - op 3 goes to SAVE_EPC.
  - op 4 goes to RESTORE.
  - Illegal op or address goes to RESP with resp_illegal=1 and no write.
- ACCESS (one cycle):
  - resp_rdata latches the pre-write value.
  - CSRRW writes wdata; CSRRS writes old|wdata; CSRRC writes old&~wdata.
  - CSRRS/CSRRC with wdata==0 perform no write.
  - Next state is RESP.
- ECALL sequence, one write per cycle:
  - SAVE_EPC: mepc<=pc&~3.
  - SAVE_CAUSE: mcause<=ECALL_CAUSE.
  - SAVE_STATUS: MPIE<=MIE, MIE<=0.
  - Then RESP with redirect_valid=1, redirect_pc=mtvec.
- MRET:
  - RESTORE: MIE<=MPIE, MPIE<=1.
  - Then RESP with redirect_valid=1, redirect_pc=mepc.
- Latency from acceptance to first resp_valid: CSR op 2 cycles, ECALL 4, MRET 2, illegal 1.
- redirect_pc is sampled in RESP, so it reflects all completed writes.
- csr_* outputs show register state and are updated at the edge of each write.

Decomposition:
- Package csr_pkg:
  - CSR address constants and op encodings.
  - FSM state enum.
  - mstatus bit positions and writable mask.
  - Reset values.
- Sub-module csr_regfile:
  - Four registers, single write port (we, index[1:0], data) applying WARL masks.
  - Four read outputs.
  - Async reset.
- csr_seq_ctrl contains the FSM, address decode and the handshake.

Test Plan:
- Reset then idle → csr_0=0x1800, csr_1..3=0, req_ready=1, resp_valid=0.
- CSRRW 0x305 wdata=0x8000_0103, then CSRRS 0x305 wdata=0 → first resp_rdata=0, mtvec=0x8000_0100; second rdata=0x8000_0100, no write.
- CSRRW 0x300 wdata=0x8; ECALL pc=0x8000_0046 → resp after 4 cycles, redirect_pc=0x8000_0100, mepc=0x8000_0044, mcause=11, mstatus=0x1880.
- MRET after the previous case → redirect_pc=0x8000_0044, mstatus=0x1888.
- CSRRW 0x7C0 and op=6 → resp_illegal=1 after 1 cycle, all csr_* unchanged.
- Hold resp_ready=0 for 5 cycles then pulse; assert reset during SAVE_CAUSE → resp stays stable and req_ready=0 while held; the reset case returns to IDLE with all reset values.
